dram_app_bram_responder: RTL
============================

DRAM_APP_BRAM_RESPONDER -- requirements
Module: dram_app_bram_responder

Interface
REQ-001 SHALL have parameter APP_ADDR_WIDTH, default 28, app_addr width (8-byte units).
REQ-002 SHALL have parameter APP_DATA_WIDTH, default 512, data width per command (one BL8 beat, 4:1).
REQ-003 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of backing-store entries (APP_DATA_WIDTH bits each).
REQ-004 SHALL have parameter RD_LATENCY, default 4, cycles from read issue to rd_data_valid (min 2).
REQ-005 SHALL have parameter CALIB_CYCLES, default 64, cycles from reset release to calibration complete.
REQ-006 SHALL have parameter THROTTLE, default 0; 1 enables periodic app_rdy drop.
REQ-007 dram_clk  in  1  sole clock, all logic rising-edge.
REQ-008 dram_rst_n  in  1  asynchronous active-low reset.
REQ-009 app_addr  in  APP_ADDR_WIDTH  command address; app_cmd  in  3  000=write, 001=read; app_en  in  1  command strobe; app_rdy  out  1  command accepted when app_en&app_rdy.
REQ-010 app_wdf_data  in  APP_DATA_WIDTH; app_wdf_mask  in  APP_DATA_WIDTH/8  1=byte not written; app_wdf_wren  in  1; app_wdf_end  in  1; app_wdf_rdy  out  1.
REQ-011 app_rd_data  out  APP_DATA_WIDTH; app_rd_data_valid  out  1; app_rd_data_end  out  1.
REQ-012 init_calib_complete  out  1; proto_err  out  1  sticky protocol-violation flag.

Function
REQ-013 SHALL implement state machine CALIB -> RUN; CALIB counts CALIB_CYCLES then enters RUN; RUN exits only on reset.
REQ-014 init_calib_complete SHALL be 1 exactly in RUN; app_rdy and app_wdf_rdy SHALL be 0 in CALIB.
REQ-015 Commands SHALL enter a 4-entry in-order command FIFO {cmd, index}; app_rdy = RUN & FIFO not full & not throttled.
REQ-016 index SHALL be app_addr[3+MEM_DEPTH_LOG2-1:3]; higher address bits ignored (wrap-around aliasing).
REQ-017 Write data SHALL enter a 4-entry write-data FIFO {data, mask} on app_wdf_wren&app_wdf_rdy; app_wdf_rdy = RUN & data FIFO not full; data may precede or follow its command.
REQ-018 At most one head command SHALL retire per cycle: write retires when data FIFO non-empty, committing bytes with mask bit 0, both FIFOs pop same cycle; read retires unconditionally.
REQ-019 Read SHALL return memory contents including every earlier-retired write; read-after-write same index returns new data.
REQ-020 Read data SHALL appear exactly RD_LATENCY cycles after retire, in command order, one cycle per read; app_rd_data_end SHALL equal app_rd_data_valid.
REQ-021 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; push when full impossible because rdy low.
REQ-022 THROTTLE=1: app_rdy SHALL be forced 0 one cycle in every 8 (free-running 3-bit counter == 7, counting in RUN); app_wdf_rdy unaffected.
REQ-023 proto_err SHALL set (sticky until reset) on: accepted app_cmd not 000/001 (command dropped); accepted app_addr[2:0] != 0 (command executed, low bits ignored); app_wdf_wren&app_wdf_rdy with app_wdf_end=0 (data still queued).
REQ-024 app_en or app_wdf_wren while rdy=0 SHALL have no effect.
REQ-025 Backing store SHALL not be initialised; reads of unwritten entries return X in simulation.

Reset
REQ-026 dram_rst_n low SHALL immediately force: state CALIB, calib counter 0, throttle counter 0, both FIFOs empty, read pipeline flushed, all outputs 0 (app_rd_data 0).
REQ-027 Reset mid-operation SHALL discard queued commands, queued data and in-flight reads; memory contents need not persist.
REQ-028 Deassertion SHALL be synchronised internally (2-flop) before leaving reset.

Verification
REQ-029 Reset release, CALIB_CYCLES=64 -> init_calib_complete, app_rdy, app_wdf_rdy rise together 64 cycles (+sync) later; all 0 before.
REQ-030 Write addr 0x40 data 0xA5.. mask 0, then read 0x40 -> rd_data_valid=rd_data_end=1 exactly RD_LATENCY cycles after read retire, data 0xA5..
REQ-031 Write with mask 0xFFFF_FFFF_FFFF_FFFE over prior 0x00.. -> subsequent read changes only byte 0.
REQ-032 Five write commands, no wdf data -> app_rdy low after 4 accepted; supply data -> drains, app_rdy returns; commands issued before data retire in order.
REQ-033 THROTTLE=1, app_en held high with reads -> exactly 7 of 8 cycles accepted; 8 reads return back-to-back in order.
REQ-034 Accepted app_cmd=3'b010, then addr 0x41 -> proto_err=1 after first, stays 1; 0x41 read returns index 0x8 data; reset clears proto_err.

Source files
------------

// File: rtl/dram_app_bram_responder_if.sv
// dram_app_bram_responder_if: app-side command, write-data and read-return bundle
interface dram_app_bram_responder_if #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 512
);
  logic [APP_ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic                        app_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_wdf_data;
  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                        app_wdf_wren;
  logic                        app_wdf_end;
  logic                        app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_rd_data;
  logic                        app_rd_data_valid;
  logic                        app_rd_data_end;
  logic                        init_calib_complete;
  logic                        proto_err;
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, proto_err
  );
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, proto_err
  );
endinterface

// File: rtl/dram_app_bram_responder.sv
// dram_app_bram_responder: BRAM-backed stand-in for a DRAM controller app interface
module dram_app_bram_responder #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 512,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64,
  parameter int THROTTLE       = 0
) (
  input logic                      dram_clk,
  input logic                      dram_rst_n,
  dram_app_bram_responder_if.slave app_io
);
  localparam int BW = APP_DATA_WIDTH / 8;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  typedef enum logic {CALIB, RUN} state_t;
  state_t                      state_q;
  logic [1:0]                  sync_q;
  logic                        rst_n;
  logic [CW-1:0]               calib_q;
  logic [2:0]                  thr_q;
  logic [2:0]                  cmd_cnt_q, cmd_cnt_d, wd_cnt_q, wd_cnt_d;
  logic [1:0]                  cmd_wp_q, cmd_rp_q, wd_wp_q, wd_rp_q;
  logic                        cmd_rd_q [4];
  logic [MEM_DEPTH_LOG2-1:0]   cmd_idx_q [4];
  logic [APP_DATA_WIDTH-1:0]   wd_data_q [4];
  logic [BW-1:0]               wd_mask_q [4];
  logic [APP_DATA_WIDTH-1:0]   mem [2**MEM_DEPTH_LOG2];
  logic [RD_LATENCY-1:0]       rv_q;
  logic [APP_DATA_WIDTH-1:0]   rd_q [RD_LATENCY];
  logic                        proto_err_q, proto_err_d;
  logic                        run, cmd_acc, cmd_ok, cmd_push, wd_push, head_rd, retire, wr_ret, rd_ret;
  logic [MEM_DEPTH_LOG2-1:0]   head_idx;
  // reset asserts asynchronously but is released only after two clean clock edges
  always_ff @(posedge dram_clk or negedge dram_rst_n)
    if (!dram_rst_n) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_n    = sync_q[1];
  assign run      = state_q == RUN;
  assign head_rd  = cmd_rd_q[cmd_rp_q];
  assign head_idx = cmd_idx_q[cmd_rp_q];
  assign cmd_acc  = app_io.app_en && app_io.app_rdy;
  assign cmd_ok   = app_io.app_cmd[2:1] == 2'b00;
  assign cmd_push = cmd_acc && cmd_ok;
  assign wd_push  = app_io.app_wdf_wren && app_io.app_wdf_rdy;
  assign retire   = cmd_cnt_q != 3'd0 && (head_rd || wd_cnt_q != 3'd0);
  assign wr_ret   = retire && !head_rd;
  assign rd_ret   = retire && head_rd;
  assign app_io.app_rdy             = run && cmd_cnt_q != 3'd4 && !(THROTTLE != 0 && thr_q == 3'd7);
  assign app_io.app_wdf_rdy         = run && wd_cnt_q != 3'd4;
  assign app_io.init_calib_complete = run;
  assign app_io.proto_err           = proto_err_q;
  assign app_io.app_rd_data         = rd_q[RD_LATENCY-1];
  assign app_io.app_rd_data_valid   = rv_q[RD_LATENCY-1];
  assign app_io.app_rd_data_end     = rv_q[RD_LATENCY-1];
  // queue occupancy and sticky protocol-violation detection
  always_comb begin
    cmd_cnt_d   = cmd_cnt_q + 3'(cmd_push) - 3'(retire);
    wd_cnt_d    = wd_cnt_q + 3'(wd_push) - 3'(wr_ret);
    proto_err_d = proto_err_q || (cmd_acc && (!cmd_ok || app_io.app_addr[2:0] != 3'd0))
                  || (wd_push && !app_io.app_wdf_end);
  end
  // calibration FSM, throttle counter and FIFO pointers
  always_ff @(posedge dram_clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= CALIB;
      calib_q     <= '0;
      thr_q       <= 3'd0;
      cmd_cnt_q   <= 3'd0;
      wd_cnt_q    <= 3'd0;
      cmd_wp_q    <= 2'd0;
      cmd_rp_q    <= 2'd0;
      wd_wp_q     <= 2'd0;
      wd_rp_q     <= 2'd0;
      proto_err_q <= 1'b0;
    end else begin
      if (state_q == CALIB) begin
        calib_q <= calib_q + 1'b1;
        if (calib_q == CW'(CALIB_CYCLES - 1)) state_q <= RUN;
      end
      thr_q       <= run ? thr_q + 3'd1 : 3'd0;
      cmd_cnt_q   <= cmd_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      cmd_wp_q    <= cmd_wp_q + 2'(cmd_push);
      cmd_rp_q    <= cmd_rp_q + 2'(retire);
      wd_wp_q     <= wd_wp_q + 2'(wd_push);
      wd_rp_q     <= wd_rp_q + 2'(wr_ret);
      proto_err_q <= proto_err_d;
    end
  // FIFO storage and byte-masked backing-store writes, no reset needed
  always_ff @(posedge dram_clk) begin
    if (cmd_push) begin
      cmd_rd_q[cmd_wp_q]  <= app_io.app_cmd[0];
      cmd_idx_q[cmd_wp_q] <= app_io.app_addr[3+MEM_DEPTH_LOG2-1:3];
    end
    if (wd_push) begin
      wd_data_q[wd_wp_q] <= app_io.app_wdf_data;
      wd_mask_q[wd_wp_q] <= app_io.app_wdf_mask;
    end
    if (wr_ret)
      for (int b = 0; b < BW; b++)
        if (!wd_mask_q[wd_rp_q][b]) mem[head_idx][b*8 +: 8] <= wd_data_q[wd_rp_q][b*8 +: 8];
  end
  // fixed-latency read return pipeline, flushed by reset
  always_ff @(posedge dram_clk or negedge rst_n)
    if (!rst_n) begin
      rv_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_q[i] <= '0;
    end else begin
      rv_q <= {rv_q[RD_LATENCY-2:0], rd_ret};
      if (rd_ret) rd_q[0] <= mem[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) rd_q[i] <= rd_q[i-1];
    end
endmodule
